// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the 8-bit Von Neumann CPU memory bus.
// The CPU core and the memory responder both import this package so their bus widths match.
package cpu_bus_pkg;

  localparam int DATA_W     = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int CNT_W      = 4;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACC
  } resp_state_e;

endpackage

// File: rtl/vn_ram_sp.sv
// Single-port synchronous byte RAM with a registered, write-first read port.
// The read register updates only when en is high.
module vn_ram_sp
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  data_t         wdata,
  output data_t         rdata
);

  data_t mem [DEPTH];
  data_t rdata_q;

  // NOTE: the array and its read register have no reset, so they map onto block RAM and the contents survive rst_n.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata_q   <= wdata;
      end else begin
        rdata_q   <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vn_mem_responder.sv
// Memory responder for the Von Neumann CPU: req/ack handshake, configurable wait states, side-band preload port.
// One RAM port is shared by the loader and the latched CPU access; the RAM is written on the edge that enters ACC.
module vn_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  data_t             wdata,
  output data_t             rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  data_t             load_data
);

  localparam int                RAM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT_STATES);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  resp_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  data_t             wdata_q, wdata_d;
  logic              oor_q, oor_d;
  data_t             rdata_q, rdata_d;

  logic              ld_sel;
  logic              acc_en;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  data_t             acc_wdata;
  logic [ADDR_W-1:0] port_addr;
  logic              port_hit;
  logic              ram_en;
  logic              ram_we;
  data_t             ram_wdata;
  data_t             ram_rdata;
  data_t             rdata_now;

  // Value on the bus during ACC; the register holds it until the next ack.
  assign rdata_now = (state_q == ACC) ? (oor_q ? '0 : ram_rdata) : rdata_q;

  // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    oor_d     = oor_q;
    rdata_d   = rdata_q;
    ld_sel    = 1'b0;
    acc_en    = 1'b0;
    acc_addr  = addr_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (load_en) begin
          ld_sel = 1'b1;
        end else if (req) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          cnt_d   = WAIT_INIT;
          if (WAIT_STATES == 0) begin
            // No wait states: the latch registers are still loading, so the live request drives the RAM port.
            acc_en    = 1'b1;
            acc_addr  = addr;
            acc_we    = we;
            acc_wdata = wdata;
            state_d   = ACC;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          acc_en  = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        rdata_d = rdata_now;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    port_addr = ld_sel ? load_addr : acc_addr;
    ram_wdata = ld_sel ? load_data : acc_wdata;
    port_hit  = in_range(port_addr);
    ram_en    = (ld_sel | acc_en) & port_hit;
    ram_we    = ld_sel | acc_we;
    if (acc_en) begin
      oor_d = !port_hit;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      rdata_q <= rdata_d;
    end
  end

  vn_ram_sp #(
    .DEPTH (MEM_DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (port_addr[RAM_AW-1:0]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign ack   = (state_q == ACC);
  assign err   = ack & oor_q;
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_now;

endmodule

// File: tb/tb_vn_mem_responder.sv
// Directed bench for vn_mem_responder: three instances (0 waits/256 B, 3 waits/128 B, 5 waits/256 B).
// All stimulus changes and all output samples happen on the falling clock edge.
module tb_vn_mem_responder;
  import cpu_bus_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       req_i       [3];
  logic       we_i        [3];
  logic [7:0] addr_i      [3];
  logic [7:0] wdata_i     [3];
  logic [7:0] rdata_o     [3];
  logic       ack_o       [3];
  logic       err_o       [3];
  logic       busy_o      [3];
  logic       load_en_i   [3];
  logic [7:0] load_addr_i [3];
  logic [7:0] load_data_i [3];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  vn_mem_responder #(.ADDR_W(8), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .req(req_i[0]), .we(we_i[0]), .addr(addr_i[0]),
    .wdata(wdata_i[0]), .rdata(rdata_o[0]), .ack(ack_o[0]), .err(err_o[0]),
    .busy(busy_o[0]), .load_en(load_en_i[0]), .load_addr(load_addr_i[0]),
    .load_data(load_data_i[0])
  );

  vn_mem_responder #(.ADDR_W(8), .MEM_DEPTH(128), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .req(req_i[1]), .we(we_i[1]), .addr(addr_i[1]),
    .wdata(wdata_i[1]), .rdata(rdata_o[1]), .ack(ack_o[1]), .err(err_o[1]),
    .busy(busy_o[1]), .load_en(load_en_i[1]), .load_addr(load_addr_i[1]),
    .load_data(load_data_i[1])
  );

  vn_mem_responder #(.ADDR_W(8), .MEM_DEPTH(256), .WAIT_STATES(5)) u_ws5 (
    .clk(clk), .rst_n(rst_n), .req(req_i[2]), .we(we_i[2]), .addr(addr_i[2]),
    .wdata(wdata_i[2]), .rdata(rdata_o[2]), .ack(ack_o[2]), .err(err_o[2]),
    .busy(busy_o[2]), .load_en(load_en_i[2]), .load_addr(load_addr_i[2]),
    .load_data(load_data_i[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input int i, input logic [7:0] a, input logic [7:0] d);
    load_en_i[i]   = 1'b1;
    load_addr_i[i] = a;
    load_data_i[i] = d;
    @(negedge clk);
    load_en_i[i]   = 1'b0;
  endtask

  // Raise req at the current falling edge and wait (bounded) for ack; req drops in the ack cycle.
  task automatic access(input int i, input logic w, input logic [7:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output logic er,
                        output logic bz, output int stamp);
    bit done;
    req_i[i]   = 1'b1;
    we_i[i]    = w;
    addr_i[i]  = a;
    wdata_i[i] = d;
    lat   = -1;
    rd    = 8'hxx;
    er    = 1'bx;
    bz    = 1'bx;
    stamp = -1;
    done  = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (ack_o[i]) begin
        lat   = c;
        rd    = rdata_o[i];
        er    = err_o[i];
        bz    = busy_o[i];
        stamp = cyc;
        done  = 1'b1;
      end
    end
    req_i[i] = 1'b0;
  endtask

  initial begin
    logic [7:0] pre [4];
    logic [7:0] rd;
    logic       er;
    logic       bz;
    int         lat;
    int         s1;
    int         s2;
    int         acks;
    logic [5:0] pattern;

    pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33; pre[3] = 8'h44;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_i[i] = 1'b0; we_i[i] = 1'b0; addr_i[i] = '0; wdata_i[i] = '0;
      load_en_i[i] = 1'b0; load_addr_i[i] = '0; load_data_i[i] = '0;
    end

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ack%0d", i),   32'(ack_o[i]),   32'h0);
      check($sformatf("rst_err%0d", i),   32'(err_o[i]),   32'h0);
      check($sformatf("rst_busy%0d", i),  32'(busy_o[i]),  32'h0);
      check($sformatf("rst_rdata%0d", i), 32'(rdata_o[i]), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) load_byte(0, 8'(k), pre[k]);
    for (int k = 0; k < 4; k++) load_byte(2, 8'(k), pre[k]);

    // Zero wait states: read 0x02.
    check("ws0_idle_busy", 32'(busy_o[0]), 32'h0);
    access(0, 1'b0, 8'h02, 8'h00, lat, rd, er, bz, s1);
    check("ws0_rd_lat",   32'(lat), 32'd1);
    check("ws0_rd_data",  32'(rd),  32'h33);
    check("ws0_rd_err",   32'(er),  32'h0);
    check("ws0_rd_busy",  32'(bz),  32'h1);
    @(negedge clk);
    check("ws0_after_busy", 32'(busy_o[0]),  32'h0);
    check("ws0_after_ack",  32'(ack_o[0]),   32'h0);
    check("ws0_rdata_hold", 32'(rdata_o[0]), 32'h33);

    // Held req: read 0x01 for six cycles, expect ack every other cycle.
    req_i[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 8'h01;
    acks = 0;
    pattern = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pattern[c] = ack_o[0];
      if (ack_o[0]) begin
        acks++;
        check($sformatf("held_rdata%0d", acks), 32'(rdata_o[0]), 32'h22);
      end
    end
    req_i[0] = 1'b0;
    check("held_acks",    32'(acks),    32'd3);
    check("held_pattern", 32'(pattern), 32'b010101);
    @(negedge clk);

    // Load and req together: load wins, read serviced one cycle later.
    load_en_i[0] = 1'b1; load_addr_i[0] = 8'h20; load_data_i[0] = 8'h77;
    req_i[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 8'h20;
    @(negedge clk);
    check("race_no_ack", 32'(ack_o[0]), 32'h0);
    load_en_i[0] = 1'b0;
    @(negedge clk);
    check("race_ack",   32'(ack_o[0]),   32'h1);
    check("race_rdata", 32'(rdata_o[0]), 32'h77);
    req_i[0] = 1'b0;
    @(negedge clk);

    // Three wait states, 128-byte memory.
    access(1, 1'b1, 8'h10, 8'hA5, lat, rd, er, bz, s1);
    check("ws3_wr_lat",  32'(lat), 32'd4);
    check("ws3_wr_echo", 32'(rd),  32'hA5);
    check("ws3_wr_err",  32'(er),  32'h0);
    @(negedge clk);
    check("ws3_ack_pulse", 32'(ack_o[1]), 32'h0);
    access(1, 1'b0, 8'h10, 8'h00, lat, rd, er, bz, s2);
    check("ws3_rd_lat",  32'(lat),     32'd4);
    check("ws3_rd_data", 32'(rd),      32'hA5);
    check("ws3_spacing", 32'(s2 - s1), 32'd5);
    @(negedge clk);
    access(1, 1'b1, 8'h90, 8'h5A, lat, rd, er, bz, s1);
    check("oor_lat",   32'(lat), 32'd4);
    check("oor_err",   32'(er),  32'h1);
    check("oor_rdata", 32'(rd),  32'h00);
    @(negedge clk);
    check("oor_err_pulse",  32'(err_o[1]),   32'h0);
    check("oor_rdata_hold", 32'(rdata_o[1]), 32'h00);
    access(1, 1'b0, 8'h10, 8'h00, lat, rd, er, bz, s1);
    check("oor_alias_data", 32'(rd), 32'hA5);
    check("oor_alias_err",  32'(er), 32'h0);
    @(negedge clk);

    // Five wait states, then reset in the middle of a write.
    access(2, 1'b0, 8'h00, 8'h00, lat, rd, er, bz, s1);
    check("ws5_rd_lat",  32'(lat), 32'd6);
    check("ws5_rd_data", 32'(rd),  32'h11);
    @(negedge clk);
    req_i[2] = 1'b1; we_i[2] = 1'b1; addr_i[2] = 8'h03; wdata_i[2] = 8'hFF;
    @(negedge clk);
    check("ws5_wait_busy", 32'(busy_o[2]), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    req_i[2] = 1'b0;
    #1;
    check("midrst_ack",   32'(ack_o[2]),   32'h0);
    check("midrst_err",   32'(err_o[2]),   32'h0);
    check("midrst_busy",  32'(busy_o[2]),  32'h0);
    check("midrst_rdata", 32'(rdata_o[2]), 32'h0);
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ack_o[2]) acks++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack_o[2] || busy_o[2]) acks++;
    end
    check("midrst_no_ack", 32'(acks), 32'd0);
    access(2, 1'b0, 8'h03, 8'h00, lat, rd, er, bz, s1);
    check("midrst_rd_lat",  32'(lat), 32'd6);
    check("midrst_rd_data", 32'(rd),  32'h44);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
